// File: rtl/aes_cbc_dec_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_cbc_dec_ctrl_if
// Ciphertext-in / plaintext-out valid/ready streams of the CBC decrypt
// sequencer.
//   in_data/in_valid/in_ready    : ciphertext block stream into the sequencer
//   out_data/out_valid/out_ready : plaintext block stream out of the sequencer
// Modports:
//   master : the environment side (drives ciphertext, consumes plaintext)
//   slave  : the sequencer side
// ---------------------------------------------------------------------------
interface aes_cbc_dec_ctrl_if;
    localparam int unsigned BLOCK_W = 128;

    logic [BLOCK_W-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/aes_cbc_dec_ctrl.sv
// ---------------------------------------------------------------------------
// aes_cbc_dec_ctrl
// Turns a single-block AES-128 decryption core into a streaming CBC
// decryptor: takes one ciphertext block, clears and starts the core, waits
// for done, XORs the core result with the chaining value and presents the
// plaintext. The key is wired straight to the core and is not seen here.
//
// Ports:
//   clk, reset   : single clock, synchronous active-high reset
//   iv, iv_load  : initialisation vector, loaded into chain only when idle
//   bus (slave)  : in_data/in_valid/in_ready ciphertext stream,
//                  out_data/out_valid/out_ready plaintext stream
//   core_clear   : one-cycle reset pulse to the core
//   core_start   : core start, held high while waiting for done
//   core_data    : ciphertext presented to the core (always the held block)
//   core_done    : core done level
//   core_result  : core decrypted data
//   err          : sticky watchdog error
//
// Build option AES_CBC_WDOG_EN: when defined, a RUN-state watchdog of
// WDOG_CYCLES (16..63) drops a block whose core never reports done and
// raises err. When undefined, RUN waits forever and err is tied low.
// ---------------------------------------------------------------------------
module aes_cbc_dec_ctrl #(
    parameter int unsigned WDOG_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [127:0]         iv,
    input  logic                 iv_load,
    aes_cbc_dec_ctrl_if.slave    bus,
    output logic                 core_clear,
    output logic                 core_start,
    output logic [127:0]         core_data,
    input  logic                 core_done,
    input  logic [127:0]         core_result,
    output logic                 err
);

    localparam int unsigned BLOCK_W = 128;

    // Elaboration-time guard on the watchdog depth (6-bit counter).
    if (WDOG_CYCLES < 16 || WDOG_CYCLES > 63) begin : g_wdog_range
        $error("aes_cbc_dec_ctrl: WDOG_CYCLES must be within 16..63");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t             state;
    logic [BLOCK_W-1:0] chain;
    logic [BLOCK_W-1:0] ct;
    logic [BLOCK_W-1:0] pt;
    logic               run_armed;
    logic               out_valid_q;

`ifdef AES_CBC_WDOG_EN
    localparam int unsigned WDOG_W = 6;
    // Last RUN cycle before the counter would reach WDOG_CYCLES-1.
    localparam logic [WDOG_W-1:0] WDOG_TRIP = WDOG_W'(WDOG_CYCLES - 2);

    logic [WDOG_W-1:0] wdog;
    logic              err_q;
`endif

    // Sequencer: state, datapath registers and registered core/stream controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            chain       <= '0;
            ct          <= '0;
            pt          <= '0;
            run_armed   <= 1'b0;
            out_valid_q <= 1'b0;
            core_clear  <= 1'b0;
            core_start  <= 1'b0;
`ifdef AES_CBC_WDOG_EN
            wdog        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            core_clear <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // iv_load wins: in_ready is low while it is asserted.
                    if (iv_load) begin
                        chain <= iv;
                    end else if (bus.in_valid) begin
                        ct         <= bus.in_data;
                        core_clear <= 1'b1;
                        state      <= ST_CLR;
                    end
                end

                ST_CLR: begin
                    core_start <= 1'b1;
                    run_armed  <= 1'b0;
`ifdef AES_CBC_WDOG_EN
                    wdog       <= '0;
`endif
                    state      <= ST_RUN;
                end

                ST_RUN: begin
                    // Done in the first RUN cycle may be left over from before
                    // the clear took effect, so it is only trusted once armed.
                    if (run_armed && core_done) begin
                        pt          <= core_result ^ chain;
                        chain       <= ct;
                        core_start  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= ST_OUT;
                    end
`ifdef AES_CBC_WDOG_EN
                    else if (wdog == WDOG_TRIP) begin
                        // Abandon the block; chain and pt keep their values.
                        wdog       <= wdog + WDOG_W'(1);
                        core_start <= 1'b0;
                        err_q      <= 1'b1;
                        state      <= ST_IDLE;
                    end
`endif
                    else begin
                        run_armed <= 1'b1;
`ifdef AES_CBC_WDOG_EN
                        wdog      <= wdog + WDOG_W'(1);
`endif
                    end
                end

                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready follows iv_load combinationally so a same-cycle IV load blocks acceptance.
    assign bus.in_ready  = (state == ST_IDLE) & ~iv_load;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = pt;
    assign core_data     = ct;

`ifdef AES_CBC_WDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_cbc_dec_ctrl
// Drives aes_cbc_dec_ctrl through directed CBC scenarios and a randomized
// phase, against a transaction-level model (chain value, expected-output
// queue, block timing) and a behavioural core with programmable latency.
// The core maps the FIPS-197 vector 69c4..c55a to 0011..eeff and every other
// block through a fixed scramble, so CBC results can be predicted.
// ---------------------------------------------------------------------------
module tb_aes_cbc_dec_ctrl;

    localparam int WDOG = 32;
    localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] iv = '0;
    logic         iv_load = 1'b0;
    logic         core_clear;
    logic         core_start;
    logic [127:0] core_data;
    logic         core_done;
    logic [127:0] core_result;
    logic         err;

    aes_cbc_dec_ctrl_if bus_if ();

    aes_cbc_dec_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .iv          (iv),
        .iv_load     (iv_load),
        .bus         (bus_if.slave),
        .core_clear  (core_clear),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_done   (core_done),
        .core_result (core_result),
        .err         (err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural decryption core ----------------
    int core_lat = 12;
    bit stale_en = 1'b0;
    int core_cnt = 0;

    function automatic logic [127:0] core_fn(input logic [127:0] x);
        if (x == KAT_CT) return KAT_PT;
        return {x[94:0], x[127:95]} ^ {4{x[31:0]}} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    always @(posedge clk) begin
        if (core_clear)
            core_cnt <= 0;
        else if (core_start && core_cnt < 1000)
            core_cnt <= core_cnt + 1;
    end

    // Optional stale done in the first start cycle after a clear.
    assign core_done   = (core_cnt >= core_lat) || (stale_en && core_cnt == 0 && core_start);
    assign core_result = (core_cnt >= core_lat) ? core_fn(core_data)
                                                : 128'hdead_beef_dead_beef_dead_beef_dead_beef;

    // ---------------- reference model ----------------
    logic [127:0] m_chain, m_prev_chain, m_ct, m_pt;
    logic [127:0] m_q[$];
    bit           m_busy = 1'b0;
    bit           m_err = 1'b0;
    bit           armed = 1'b0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           blk_lat = 0;
    int           first_ov_cyc = -1;
    int           n_acc = 0;
    int           n_take = 0;
    logic [127:0] got_out = '0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: check this cycle's outputs, then advance the model across the edge.
    task automatic tick();
        logic exp_ov;
        logic do_acc, do_take, do_drop;
        #1;
        exp_ov = m_busy && (cyc >= acc_cyc + 3 + blk_lat);
        if (armed) begin
            check("in_ready",   128'(bus_if.in_ready),  128'(!m_busy && !iv_load));
            check("out_valid",  128'(bus_if.out_valid), 128'(exp_ov));
            check("core_clear", 128'(core_clear),       128'(m_busy && cyc == acc_cyc + 1));
            check("core_start", 128'(core_start),
                  128'(m_busy && cyc >= acc_cyc + 2 && cyc < acc_cyc + 3 + blk_lat));
            check("core_data",  core_data,              m_ct);
            check("out_data",   bus_if.out_data,        exp_ov ? m_q[0] : m_pt);
            check("err",        128'(err),              128'(m_err));
        end
        if (bus_if.out_valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (bus_if.out_valid === 1'b1 && bus_if.out_ready) got_out = bus_if.out_data;

        if (reset) begin
            m_chain = '0; m_prev_chain = '0; m_ct = '0; m_pt = '0;
            m_busy = 1'b0; m_err = 1'b0; m_q.delete();
            first_ov_cyc = -1;
            armed = 1'b1;
        end else begin
            do_drop = 1'b0;
`ifdef AES_CBC_WDOG_EN
            do_drop = m_busy && (blk_lat > WDOG - 2) && (cyc == acc_cyc + WDOG);
`endif
            do_take = exp_ov && bus_if.out_ready;
            do_acc  = !m_busy && !iv_load && bus_if.in_valid;
            if (!m_busy && iv_load) m_chain = iv;
            if (do_acc) begin
                m_prev_chain = m_chain;
                m_q.push_back(core_fn(bus_if.in_data) ^ m_chain);
                m_chain = bus_if.in_data;
                m_ct = bus_if.in_data;
                acc_cyc = cyc;
                blk_lat = core_lat;
                first_ov_cyc = -1;
                m_busy = 1'b1;
                n_acc++;
            end
            if (do_take) begin
                m_pt = m_q.pop_front();
                m_busy = 1'b0;
                n_take++;
            end
            if (do_drop) begin
                m_chain = m_prev_chain;
                void'(m_q.pop_back());
                m_busy = 1'b0;
                m_err = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [127:0] d);
        int a0;
        a0 = n_acc;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        for (int i = 0; i < 300 && n_acc == a0; i++) tick();
        bus_if.in_valid = 1'b0;
        if (n_acc == a0) check("send_timeout", 128'(n_acc), 128'(a0 + 1));
    endtask

    task automatic recv(output logic [127:0] d);
        int t0;
        t0 = n_take;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 300 && n_take == t0; i++) tick();
        if (n_take == t0) check("recv_timeout", 128'(n_take), 128'(t0 + 1));
        d = got_out;
    endtask

    initial begin
        logic [127:0] got, hold, r_iv, blk;
        int a0;

        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_data", bus_if.out_data, 128'h0);
        check("rst_in_ready", 128'(bus_if.in_ready), 128'h1);

        // IV load then a single FIPS-197 block, 15-cycle latency
        iv = 128'h000102030405060708090a0b0c0d0e0f;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        send(KAT_CT);
        recv(got);
        check("kat_iv_pt", got, 128'h00102030405060708090a0b0c0d0e0f0);
        check("kat_latency", 128'(first_ov_cyc - acc_cyc), 128'(15));

        // Chaining with a zero IV
        iv = '0;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        send(KAT_CT);
        recv(got);
        check("chain_blk0", got, KAT_PT);
        send(KAT_CT);
        recv(got);
        check("chain_blk1", got, 128'h69d5c2eb2e2e624750541d3bbc692ba5);

        // Output backpressure with a pending input
        bus_if.out_ready = 1'b0;
        send(128'h0123456789abcdeffedcba9876543210);
        for (int i = 0; i < 100 && bus_if.out_valid !== 1'b1; i++) tick();
        check("bp_wait_ov", 128'(bus_if.out_valid), 128'h1);
        hold = bus_if.out_data;
        a0 = n_acc;
        blk = rand128();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = blk;
        repeat (20) tick();
        check("bp_stable", bus_if.out_data, hold);
        check("bp_in_ready", 128'(bus_if.in_ready), 128'h0);
        check("bp_no_accept", 128'(n_acc), 128'(a0));
        recv(got);
        check("bp_first", got, core_fn(128'h0123456789abcdeffedcba9876543210) ^ KAT_CT);
        check("bp_not_same_cycle", 128'(n_acc), 128'(a0));
        tick();
        check("bp_accept_next", 128'(n_acc), 128'(a0 + 1));
        bus_if.in_valid = 1'b0;
        recv(got);
        check("bp_second", got, core_fn(blk) ^ 128'h0123456789abcdeffedcba9876543210);

        // iv_load and in_valid in the same idle cycle
        r_iv = rand128();
        iv = r_iv;
        iv_load = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = KAT_CT;
        a0 = n_acc;
        #1;
        check("hs_same_in_ready", 128'(bus_if.in_ready), 128'h0);
        tick();
        iv_load = 1'b0;
        check("hs_same_no_accept", 128'(n_acc), 128'(a0));
        send(KAT_CT);
        recv(got);
        check("hs_same_pt", got, KAT_PT ^ r_iv);

        // iv_load while the block is in RUN is ignored
        blk = rand128();
        send(blk);
        repeat (4) tick();
        iv = rand128();
        iv_load = 1'b1;
        repeat (3) tick();
        iv_load = 1'b0;
        recv(got);
        check("hs_run_ivload", got, core_fn(blk) ^ KAT_CT);

        // Reset in the middle of RUN
        send(rand128());
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_in_ready", 128'(bus_if.in_ready), 128'h1);
        check("rstmid_out_valid", 128'(bus_if.out_valid), 128'h0);
        check("rstmid_core_start", 128'(core_start), 128'h0);
        check("rstmid_core_data", core_data, 128'h0);
        repeat (20) tick();
        send(KAT_CT);
        recv(got);
        check("rstmid_chain_zero", got, KAT_PT);

`ifdef AES_CBC_WDOG_EN
        // Core never finishes: block dropped, err set, chain untouched
        core_lat = 1000;
        send(rand128());
        for (int i = 0; i < 60 && err !== 1'b1; i++) tick();
        check("wdog_err", 128'(err), 128'h1);
        check("wdog_idle", 128'(bus_if.in_ready), 128'h1);
        core_lat = 12;
        send(KAT_CT);
        recv(got);
        check("wdog_next_block", got, 128'h69d5c2eb2e2e624750541d3bbc692ba5);
`else
        check("no_wdog_err", 128'(err), 128'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset            = ($urandom_range(0, 599) == 0);
            iv_load          = ($urandom_range(0, 15) == 0);
            iv               = rand128();
            bus_if.in_valid  = ($urandom_range(0, 2) != 0);
            bus_if.in_data   = ($urandom_range(0, 7) == 0) ? KAT_CT : rand128();
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            if (!m_busy) begin
                core_lat = $urandom_range(1, 20);
                stale_en = ($urandom_range(0, 1) == 1);
`ifdef AES_CBC_WDOG_EN
                if ($urandom_range(0, 9) == 0) core_lat = 40;
`endif
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
